// File: rtl/keypad_scanner_if.sv
// Keypad matrix lines plus the debounced key event outputs of keypad_scanner.
interface keypad_scanner_if;
    logic [3:0] row_i;
    logic [3:0] col_o;
    logic [3:0] key_code_o;
    logic       key_valid_o;
    logic       key_held_o;

    modport master (input row_i, output col_o, key_code_o, key_valid_o, key_held_o);
    modport slave  (output row_i, input col_o, key_code_o, key_valid_o, key_held_o);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, 2-FF row sync, frame-level debounce, press events.
// Defining KEY_REPEAT_EN adds auto-repeat pulses every REPEAT_DLY frames while held.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned DEB_SCANS  = 4,
    parameter int unsigned REPEAT_DLY = 200
) (
    input  logic             CLK_clk_i,
    input  logic             RST_rst_i,
    keypad_scanner_if.master kp
);
    localparam int unsigned PW = $clog2(SCAN_DIV);
    localparam int unsigned DW = $clog2(DEB_SCANS + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_SCANS - 1);

    typedef enum logic [1:0] {IDLE, DEB, PRESSED, REL} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [3:0]    cand_q, cand_d;
    logic [PW-1:0] presc_q;
    logic [1:0]    col_idx_q, col_nxt;
    logic [3:0]    col_q;
    logic [3:0]    row_s1_q, row_s2_q;
    logic [15:0]   acc_q, samp_c, full_c;
    logic [3:0]    code_c, key_code_q;
    logic [1:0]    n_low_c;
    logic          tick_c, frame_end_c, single_c, match_c;
    logic          accept_c, release_c, rep_hit_c;
    logic          key_valid_q, key_held_q;

    assign tick_c      = (presc_q == PRESC_LAST);
    assign frame_end_c = tick_c && (col_idx_q == 2'd3);
    assign col_nxt     = col_idx_q + 2'd1;

    // Frame result including this tick's sample; count saturates at 2 (MULTI).
    always_comb begin
        samp_c  = '0;
        code_c  = '0;
        n_low_c = 2'd0;
        for (int r = 0; r < 4; r++) begin
            samp_c[{2'(r), col_idx_q}] = ~row_s2_q[2'(r)];
        end
        full_c = acc_q | samp_c;
        for (int i = 0; i < 16; i++) begin
            if (full_c[4'(i)]) begin
                code_c = 4'(i);
                if (n_low_c != 2'd2) n_low_c = n_low_c + 2'd1;
            end
        end
    end

    assign single_c = (n_low_c == 2'd1);
    assign match_c  = single_c && (code_c == cand_q);

    always_ff @(posedge CLK_clk_i) begin
        if (!RST_rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
        end
    end

    // Debounce FSM, advanced only at frame ends.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cand_d    = cand_q;
        accept_c  = 1'b0;
        release_c = 1'b0;
        if (frame_end_c) begin
            unique case (state_q)
                IDLE: if (single_c) begin
                    cand_d = code_c;
                    cnt_d  = DW'(1);
                    if (DEB_SCANS == 1) begin
                        state_d  = PRESSED;
                        accept_c = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        state_d = DEB;
                    end
                end
                DEB: if (match_c) begin
                    cnt_d = cnt_q + DW'(1);
                    if (cnt_q == DEB_LAST) begin
                        state_d  = PRESSED;
                        accept_c = 1'b1;
                        cnt_d    = '0;
                    end
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
                PRESSED: if (!match_c) begin
                    if (DEB_SCANS == 1) begin
                        state_d   = IDLE;
                        release_c = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        state_d = REL;
                        cnt_d   = DW'(1);
                    end
                end
                REL: if (match_c) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                    if (cnt_q == DEB_LAST) begin
                        state_d   = IDLE;
                        release_c = 1'b1;
                        cnt_d     = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int unsigned RW = $clog2(REPEAT_DLY + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_DLY - 1);
    logic [RW-1:0] rep_q;

    assign rep_hit_c = frame_end_c && (state_q == PRESSED) && match_c && (rep_q == REP_LAST);

    // Held-frame counter; only runs while settled in PRESSED.
    always_ff @(posedge CLK_clk_i) begin
        if (!RST_rst_i || state_q != PRESSED) rep_q <= '0;
        else if (frame_end_c) rep_q <= (!match_c || rep_hit_c) ? '0 : rep_q + RW'(1);
    end
`else
    logic unused_repeat_dly;
    assign unused_repeat_dly = ^32'(REPEAT_DLY);
    assign rep_hit_c = 1'b0;
`endif

    // Prescaler, column drive, row sync, frame accumulator and registered outputs.
    always_ff @(posedge CLK_clk_i) begin
        if (!RST_rst_i) begin
            presc_q     <= '0;
            col_idx_q   <= 2'd0;
            col_q       <= 4'b1110;
            row_s1_q    <= 4'b1111;
            row_s2_q    <= 4'b1111;
            acc_q       <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            row_s1_q <= kp.row_i;
            row_s2_q <= row_s1_q;
            presc_q  <= tick_c ? '0 : presc_q + PW'(1);
            if (tick_c) begin
                col_idx_q <= col_nxt;
                col_q     <= ~(4'b0001 << col_nxt);
                acc_q     <= frame_end_c ? '0 : full_c;
            end
            key_valid_q <= accept_c | rep_hit_c;
            if (accept_c) begin
                key_code_q <= cand_d;
                key_held_q <= 1'b1;
            end else if (release_c) begin
                key_held_q <= 1'b0;
            end
        end
    end

    assign kp.col_o       = col_q;
    assign kp.key_code_o  = key_code_q;
    assign kp.key_valid_o = key_valid_q;
    assign kp.key_held_o  = key_held_q;
endmodule
